hack_cpu_seq: RTL and testbench



---
 rtl/hack_pkg.sv | 26 ++
 rtl/hack_jump_eval.sv | 16 +
 rtl/hack_cpu_seq.sv | 159 +++++++++++++++
 tb/tb_hack_cpu_seq.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared types and instruction field positions for the Hack CPU sequencer.
// Field positions are bit indices into the 16-bit instruction register.
package hack_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        MEMRD  = 3'd2,
        EXEC   = 3'd3,
        MEMWR  = 3'd4
    } state_t;

    localparam int IS_C   = 15;
    localparam int A_BIT  = 12;
    localparam int CMP_HI = 11;
    localparam int CMP_LO = 6;
    localparam int D_A    = 5;
    localparam int D_D    = 4;
    localparam int D_M    = 3;
    localparam int J_LT   = 2;
    localparam int J_EQ   = 1;
    localparam int J_GT   = 0;

    localparam logic [14:0] RESET_PC = 15'd0;

endpackage

// File: rtl/hack_jump_eval.sv
// Combinational jump decision from the C-instruction jump field and ALU flags.
// Zero latency; no flow control.
module hack_jump_eval
    import hack_pkg::*;
(
    input  logic [2:0] j,
    input  logic       zr,
    input  logic       ng,
    output logic       jump
);

    assign jump = (j[J_LT - J_GT] & ng)
                | (j[J_EQ - J_GT] & zr)
                | (j[0] & ~ng & ~zr);

endmodule

// File: rtl/hack_cpu_seq.sv
// Multi-cycle Hack CPU sequencer: FETCH/DECODE/[MEMRD]/EXEC/[MEMWR], 2-5 cycles per instruction
// at zero wait; every memory wait stalls the current state with request outputs held constant.
module hack_cpu_seq
    import hack_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [14:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [14:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [15:0] dmem_rdata,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic        alu_zx,
    output logic        alu_nx,
    output logic        alu_zy,
    output logic        alu_ny,
    output logic        alu_f,
    output logic        alu_no,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng,
    output logic [14:0] pc,
    output logic [15:0] a_reg,
    output logic [15:0] d_reg,
    output logic        retire
);

    state_t      state_q, state_d;
    logic [14:0] pc_q, pc_d;
    logic [15:0] a_q, a_d;
    logic [15:0] d_q, d_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] m_q, m_d;
    logic [15:0] wdata_q, wdata_d;
    logic [14:0] waddr_q, waddr_d;
    logic        jump;
    logic        retire_c;

    hack_jump_eval u_jump (
        .j    (ir_q[J_LT:J_GT]),
        .zr   (alu_zr),
        .ng   (alu_ng),
        .jump (jump)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            a_q     <= '0;
            d_q     <= '0;
            ir_q    <= '0;
            m_q     <= '0;
            wdata_q <= '0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            d_q     <= d_d;
            ir_q    <= ir_d;
            m_q     <= m_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        a_d        = a_q;
        d_d        = d_q;
        ir_d       = ir_q;
        m_d        = m_q;
        wdata_d    = wdata_q;
        waddr_d    = waddr_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        alu_x      = '0;
        alu_y      = '0;
        {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = 6'b0;
        retire_c   = 1'b0;

        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    ir_d    = imem_data;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (!ir_q[IS_C]) begin
                    a_d      = ir_q;
                    pc_d     = pc_q + 15'd1;
                    retire_c = 1'b1;
                    state_d  = FETCH;
                end else if (ir_q[A_BIT]) begin
                    state_d = MEMRD;
                end else begin
                    state_d = EXEC;
                end
            end
            MEMRD: begin
                dmem_req  = 1'b1;
                dmem_addr = a_q[14:0];
                if (dmem_ready) begin
                    m_d     = dmem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_x = d_q;
                alu_y = ir_q[A_BIT] ? m_q : a_q;
                {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ir_q[CMP_HI:CMP_LO];
                if (ir_q[D_A]) a_d = alu_out;
                if (ir_q[D_D]) d_d = alu_out;
                // Jump target and write address both use A as it was before this edge.
                pc_d = jump ? a_q[14:0] : pc_q + 15'd1;
                if (ir_q[D_M]) begin
                    wdata_d = alu_out;
                    waddr_d = a_q[14:0];
                    state_d = MEMWR;
                end else begin
                    retire_c = 1'b1;
                    state_d  = FETCH;
                end
            end
            MEMWR: begin
                dmem_req   = 1'b1;
                dmem_we    = 1'b1;
                dmem_addr  = waddr_q;
                dmem_wdata = wdata_q;
                if (dmem_ready) begin
                    retire_c = 1'b1;
                    state_d  = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign a_reg     = a_q;
    assign d_reg     = d_q;
    assign retire    = retire_c & ~reset;

endmodule

// File: tb/tb_hack_cpu_seq.sv
// Scoreboard bench for hack_cpu_seq: memory/ALU responders, architectural reference model, monitor.
module tb_hack_cpu_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, dmem_req, dmem_we, retire;
    logic [14:0] imem_addr, dmem_addr, pc;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_data  = '0;
    logic        dmem_ready = 1'b0;
    logic [15:0] dmem_rdata = '0;
    logic [15:0] dmem_wdata, alu_x, alu_y, a_reg, d_reg;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic [15:0] alu_out;
    logic        alu_zr, alu_ng;
    logic [5:0]  alu_ctl;

    hack_cpu_seq dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .alu_x(alu_x), .alu_y(alu_y),
        .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
        .pc(pc), .a_reg(a_reg), .d_reg(d_reg), .retire(retire)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        tests++;
        fails++;
        $display("FAIL %s: expectation missing or bound expired", name);
    endtask

    // Hack ALU behaviour as defined by the ISA.
    function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
        logic [15:0] xx, yy, o;
        xx = c[5] ? 16'h0 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 16'h0 : y;
        if (c[2]) yy = ~yy;
        o = c[1] ? xx + yy : xx & yy;
        if (c[0]) o = ~o;
        return o;
    endfunction

    assign alu_ctl = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};
    always_comb begin
        alu_out = hack_alu(alu_x, alu_y, alu_ctl);
        alu_zr  = (alu_out == 16'h0);
        alu_ng  = alu_out[15];
    end

    logic [15:0] rom  [32768];
    logic [15:0] dram [32768];
    logic [15:0] mram [32768];

    typedef struct packed {
        logic [14:0] pc;
        logic [15:0] a;
        logic [15:0] d;
    } arch_t;

    arch_t       arch_q[$];
    int          lat_q[$];
    logic [30:0] wr_q[$];
    logic [14:0] rd_q[$];
    logic [37:0] alu_q[$];

    logic [14:0] m_pc = '0;
    logic [15:0] m_a  = '0;
    logic [15:0] m_d  = '0;

    // Architectural execution of one instruction; pushes everything the DUT should show for it.
    task automatic ref_step(input logic [15:0] ins);
        logic [15:0] y, o;
        logic [5:0]  c;
        logic        jmp;
        int          lat;
        if (!ins[15]) begin
            m_a  = ins;
            m_pc = m_pc + 15'd1;
            lat  = 2;
        end else begin
            lat = 3;
            c   = ins[11:6];
            if (ins[12]) begin
                y = mram[m_a[14:0]];
                rd_q.push_back(m_a[14:0]);
                lat++;
            end else begin
                y = m_a;
            end
            o = hack_alu(m_d, y, c);
            if ({m_d, y, c} != 38'd0) alu_q.push_back({m_d, y, c});
            if (ins[3]) begin
                wr_q.push_back({m_a[14:0], o});
                mram[m_a[14:0]] = o;
                lat++;
            end
            jmp  = (ins[2] && $signed(o) < 0) || (ins[1] && o == 16'h0) || (ins[0] && $signed(o) > 0);
            m_pc = jmp ? m_a[14:0] : m_pc + 15'd1;
            if (ins[5]) m_a = o;
            if (ins[4]) m_d = o;
        end
        arch_q.push_back('{pc: m_pc, a: m_a, d: m_d});
        lat_q.push_back(lat);
    endtask

    int imem_wmax = 0;
    int dmem_wmax = 0;
    int dwr_fixed = -1;
    bit spur      = 1'b0;
    int iwaits    = 0;
    int dwaits    = 0;
    int iw        = -1;
    int dw        = -1;

    // Instruction memory responder; also the point where the reference model consumes instructions.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            imem_valid = 1'b0;
            iw = -1;
            m_pc = '0; m_a = '0; m_d = '0;
            arch_q.delete(); lat_q.delete(); wr_q.delete(); rd_q.delete(); alu_q.delete();
        end else if (imem_req) begin
            if (iw < 0) iw = $urandom_range(imem_wmax, 0);
            if (iw == 0) begin
                imem_valid = 1'b1;
                imem_data  = rom[imem_addr];
                chk("fetch_addr", 32'(imem_addr), 32'(m_pc));
                ref_step(imem_data);
                iw = -1;
            end else begin
                imem_valid = 1'b0;
                iw--;
                iwaits++;
            end
        end else begin
            imem_valid = spur ? 1'($urandom_range(1, 0)) : 1'b0;
            imem_data  = 16'($urandom);
            iw = -1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (reset) begin
            dmem_ready = 1'b0;
            dw = -1;
        end else if (dmem_req) begin
            if (dw < 0) dw = (dmem_we && dwr_fixed >= 0) ? dwr_fixed : $urandom_range(dmem_wmax, 0);
            if (dw == 0) begin
                dmem_ready = 1'b1;
                if (dmem_we) dram[dmem_addr] = dmem_wdata;
                dmem_rdata = dram[dmem_addr];
                dw = -1;
            end else begin
                dmem_ready = 1'b0;
                dmem_rdata = 16'($urandom);
                dw--;
                dwaits++;
            end
        end else begin
            dmem_ready = spur ? 1'($urandom_range(1, 0)) : 1'b0;
            dmem_rdata = 16'($urandom);
            dw = -1;
        end
    end

    int          cyc     = -1;
    int          retires = 0;
    int          wbase   = 0;
    bit          pend    = 1'b0;
    bit          prev_iw = 1'b0;
    bit          prev_dw = 1'b0;
    logic [14:0] p_iaddr, p_daddr;
    logic [15:0] p_wdata;
    logic        p_we;

    always @(negedge clk) begin
        arch_t       e;
        logic [30:0] w;
        logic [37:0] al;
        if (pend) begin
            pend = 1'b0;
            if (arch_q.size() == 0) bad("arch_underflow");
            else begin
                e = arch_q.pop_front();
                chk("arch_pc", 32'(pc), 32'(e.pc));
                chk("arch_a", 32'(a_reg), 32'(e.a));
                chk("arch_d", 32'(d_reg), 32'(e.d));
            end
        end
        if (reset) begin
            chk("no_retire_in_reset", 32'(retire), 32'd0);
            cyc = -1; retires = 0; wbase = iwaits + dwaits;
            prev_iw = 1'b0; prev_dw = 1'b0;
        end else begin
            cyc++;
            if (prev_iw) begin
                chk("imem_hold_req", 32'(imem_req), 32'd1);
                chk("imem_hold_addr", 32'(imem_addr), 32'(p_iaddr));
            end
            if (prev_dw) begin
                chk("dmem_hold_req", 32'(dmem_req), 32'd1);
                chk("dmem_hold_we", 32'(dmem_we), 32'(p_we));
                chk("dmem_hold_addr", 32'(dmem_addr), 32'(p_daddr));
                if (p_we) chk("dmem_hold_wdata", 32'(dmem_wdata), 32'(p_wdata));
            end
            prev_iw = imem_req && !imem_valid;
            prev_dw = dmem_req && !dmem_ready;
            p_iaddr = imem_addr; p_daddr = dmem_addr; p_wdata = dmem_wdata; p_we = dmem_we;
            if (dmem_req && dmem_ready) begin
                if (dmem_we) begin
                    if (wr_q.size() == 0) bad("wr_unexpected");
                    else begin
                        w = wr_q.pop_front();
                        chk("wr_addr", 32'(dmem_addr), 32'(w[30:16]));
                        chk("wr_data", 32'(dmem_wdata), 32'(w[15:0]));
                    end
                end else begin
                    if (rd_q.size() == 0) bad("rd_unexpected");
                    else chk("rd_addr", 32'(dmem_addr), 32'(rd_q.pop_front()));
                end
            end
            if ({alu_x, alu_y, alu_ctl} != 38'd0) begin
                if (alu_q.size() == 0) bad("alu_unexpected");
                else begin
                    al = alu_q.pop_front();
                    chk("alu_x", 32'(alu_x), 32'(al[37:22]));
                    chk("alu_y", 32'(alu_y), 32'(al[21:6]));
                    chk("alu_ctl", 32'(alu_ctl), 32'(al[5:0]));
                end
            end
            if (retire) begin
                if (lat_q.size() == 0) bad("retire_unexpected");
                else chk("latency", 32'(cyc), 32'(lat_q.pop_front() + iwaits + dwaits - wbase));
                wbase = iwaits + dwaits;
                cyc = 0;
                retires++;
                pend = 1'b1;
            end
        end
    end

    task automatic run_until(input int n, input int budget);
        int c = 0;
        @(posedge clk); #3 reset = 1'b0;
        while (retires < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        if (retires < n) bad("retire_timeout");
        @(posedge clk);
        @(posedge clk); #3 reset = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    int unsigned dir_addr[26] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12,
                                  100, 101, 102, 103, 104, 105,
                                  200, 201, 202, 203, 204, 205, 32767};
    logic [15:0] dir_ins[26]  = '{16'h0005, 16'h0003, 16'hEC10, 16'h0005, 16'hE090, 16'h0007,
                                  16'hFC20, 16'h0001, 16'hEC10, 16'h0010, 16'hE548, 16'h0064, 16'hEA87,
                                  16'h0001, 16'hEC10, 16'hE302, 16'hEE90, 16'h00C8, 16'hE304,
                                  16'h0003, 16'hEC28, 16'h0003, 16'hEDE8, 16'h7FFF, 16'hEA87,
                                  16'h0005};

    initial begin
        int c;
        for (int i = 0; i < 32768; i++) begin
            rom[i] = '0; dram[i] = '0; mram[i] = '0;
        end
        foreach (dir_addr[i]) rom[dir_addr[i]] = dir_ins[i];
        dram[7] = 16'h0010;
        mram[7] = 16'h0010;
        dwr_fixed = 2;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_req", 32'(imem_req), 32'd1);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_a", 32'(a_reg), 32'd0);
        chk("rst_d", 32'(d_reg), 32'd0);
        chk("rst_alu", 32'({alu_x, alu_ctl}), 32'd0);

        run_until(26, 2000);

        for (int i = 0; i < 32768; i++) begin
            rom[i]  = ($urandom_range(1, 0) == 1) ? {3'b111, 13'($urandom)} : {1'b0, 15'($urandom)};
            dram[i] = 16'($urandom);
            mram[i] = dram[i];
        end
        imem_wmax = 2; dmem_wmax = 2; dwr_fixed = -1; spur = 1'b1;
        run_until(400, 20000);

        rom[0] = 16'h0009; rom[1] = 16'hEC10; rom[2] = 16'hE308; rom[3] = 16'h0000;
        imem_wmax = 0; dmem_wmax = 0; dwr_fixed = 1000; spur = 1'b0;
        @(posedge clk); #3 reset = 1'b0;
        c = 0;
        while (!(dmem_req && dmem_we) && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("memwr_reached", 32'(dmem_req && dmem_we), 32'd1);
        chk("memwr_addr", 32'(dmem_addr), 32'd9);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_dmem_req", 32'(dmem_req), 32'd0);
        chk("abort_pc", 32'(pc), 32'd0);
        chk("abort_a", 32'(a_reg), 32'd0);
        chk("abort_d", 32'(d_reg), 32'd0);
        chk("abort_imem_req", 32'(imem_req), 32'd1);
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
